// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder
// Latched request, fixed latency, registered response with backpressure.
module dmem_responder #(
  parameter int                AWIDTH      = 32,
  parameter int                DWIDTH      = 32,
  parameter logic [AWIDTH-1:0] BASE_ADDR   = 32'h02000000,
  parameter int                DEPTH_WORDS = 1024,
  parameter int                LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [AWIDTH-1:0] req_addr_i,
  input  logic [DWIDTH-1:0] req_data_i,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DWIDTH-1:0] rsp_data_o,
  output logic              rsp_err_o,
  output logic              busy_o
);

  localparam int IDXW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [AWIDTH:0] LIMIT =
    {1'b0, BASE_ADDR} + (AWIDTH+1)'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state, state_n;

  logic [3:0] cnt, cnt_n;
  logic       rdy_q;
  logic       accept;
  logic       enter_resp;
  logic       commit;

  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] data_q;
  logic              we_q;
  logic [2:0]        f3_q;

  logic [AWIDTH-1:0] cur_addr;
  logic [DWIDTH-1:0] cur_data;
  logic              cur_we;
  logic [2:0]        cur_f3;

  logic [AWIDTH-1:0] offset;
  logic [IDXW-1:0]   idx;
  logic              in_range;
  logic              misal;
  logic              bad_op;
  logic              err;

  logic [31:0] rd_word;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ld_val;
  logic [3:0]  be;
  logic [31:0] wd;

  logic              rsp_valid_q;
  logic [DWIDTH-1:0] rsp_data_q;
  logic              rsp_err_q;

  logic [31:0] mem [DEPTH_WORDS];

  assign req_ready_o = rdy_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
  assign busy_o      = (state != IDLE);

  assign accept = req_valid_i & rdy_q;

  // With LATENCY=1 the response is formed on the accept edge itself,
  // so the live request is used in IDLE and the latched copy after.
  always_comb begin
    cur_addr = addr_q;
    cur_data = data_q;
    cur_we   = we_q;
    cur_f3   = f3_q;
    if (state == IDLE) begin
      cur_addr = req_addr_i;
      cur_data = req_data_i;
      cur_we   = req_we_i;
      cur_f3   = req_funct3_i;
    end
  end

  assign offset   = cur_addr - BASE_ADDR;
  assign idx      = IDXW'(offset >> 2);
  assign in_range = (cur_addr >= BASE_ADDR) &&
                    ({1'b0, cur_addr} < LIMIT);

  // Classify the access: size-based misalignment and illegal funct3.
  always_comb begin
    misal  = 1'b0;
    bad_op = 1'b0;
    unique case (cur_f3[1:0])
      2'b00:   misal = 1'b0;
      2'b01:   misal = cur_addr[0];
      2'b10:   misal = |cur_addr[1:0];
      default: bad_op = 1'b1;
    endcase
    if (cur_f3[2] && (cur_we || cur_f3[1]))
      bad_op = 1'b1;
  end

  assign err = bad_op | misal | ~in_range;

  assign rd_word = in_range ? mem[idx] : 32'd0;
  assign byte_v  = rd_word[{cur_addr[1:0], 3'b000} +: 8];
  assign half_v  = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];

  // Load result with sign/zero extension; zero for stores and errors.
  always_comb begin
    ld_val = 32'd0;
    if (!cur_we && !err) begin
      unique case (cur_f3)
        3'b000:  ld_val = {{24{byte_v[7]}}, byte_v};
        3'b001:  ld_val = {{16{half_v[15]}}, half_v};
        3'b010:  ld_val = rd_word;
        3'b100:  ld_val = {24'd0, byte_v};
        3'b101:  ld_val = {16'd0, half_v};
        default: ld_val = 32'd0;
      endcase
    end
  end

  // Store lane enables and lane-replicated write data.
  always_comb begin
    be = 4'b0000;
    wd = 32'd0;
    unique case (cur_f3[1:0])
      2'b00: begin
        be = 4'b0001 << cur_addr[1:0];
        wd = {4{cur_data[7:0]}};
      end
      2'b01: begin
        be = cur_addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{cur_data[15:0]}};
      end
      2'b10: begin
        be = 4'b1111;
        wd = cur_data[31:0];
      end
      default: begin
        be = 4'b0000;
        wd = 32'd0;
      end
    endcase
  end

  assign commit = enter_resp & cur_we & ~err;

  // Next-state logic; WAIT is left on the edge the counter reaches 0.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    enter_resp = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          cnt_n = 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_n    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_n    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, counter, request latch and registered response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      rdy_q       <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      we_q        <= 1'b0;
      f3_q        <= 3'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      rdy_q <= (state_n == IDLE);
      if (accept) begin
        addr_q <= req_addr_i;
        data_q <= req_data_i;
        we_q   <= req_we_i;
        f3_q   <= req_funct3_i;
      end
      if (enter_resp) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= DWIDTH'(ld_val);
        rsp_err_q   <= err;
      end else if (state == RESP && rsp_ready_i) begin
        rsp_valid_q <= 1'b0;
        rsp_data_q  <= '0;
        rsp_err_q   <= 1'b0;
      end
    end
  end

  // Byte-lane store commit; contents survive reset.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b])
          mem[idx][8*b +: 8] <= wd[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed + randomized checks of dmem_responder
// Two instances: default latency (index 0) and LATENCY=1 (index 1).
module tb_dmem_responder;

  localparam logic [31:0] BASE = 32'h02000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        qv [2];
  logic        qr [2];
  logic [31:0] qa [2];
  logic [31:0] qd [2];
  logic        qw [2];
  logic [2:0]  qf [2];
  logic        pv [2];
  logic        pr [2];
  logic [31:0] pd [2];
  logic        pe [2];
  logic        bz [2];

  logic [31:0] mm [2][1024];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_responder u_l2 (
    .clk(clk), .rst(rst),
    .req_valid_i(qv[0]), .req_ready_o(qr[0]),
    .req_addr_i(qa[0]), .req_data_i(qd[0]),
    .req_we_i(qw[0]), .req_funct3_i(qf[0]),
    .rsp_valid_o(pv[0]), .rsp_ready_i(pr[0]),
    .rsp_data_o(pd[0]), .rsp_err_o(pe[0]),
    .busy_o(bz[0])
  );

  dmem_responder #(.LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst),
    .req_valid_i(qv[1]), .req_ready_o(qr[1]),
    .req_addr_i(qa[1]), .req_data_i(qd[1]),
    .req_we_i(qw[1]), .req_funct3_i(qf[1]),
    .rsp_valid_o(pv[1]), .rsp_ready_i(pr[1]),
    .rsp_data_o(pd[1]), .rsp_err_o(pe[1]),
    .busy_o(bz[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: byte-addressed access semantics from size/offset arithmetic.
  function automatic void model(input int k, input logic [31:0] a,
                                input logic w, input logic [2:0] f,
                                input logic [31:0] d,
                                output logic [31:0] r, output logic e);
    logic [31:0] off, word, mask, v;
    int sz, wi, b;
    logic legal, in;
    legal = 1'b1;
    sz = 1;
    if (w) begin
      if (f <= 3'd2) sz = 1 << f;
      else legal = 1'b0;
    end else begin
      case (f)
        3'd0, 3'd4: sz = 1;
        3'd1, 3'd5: sz = 2;
        3'd2:       sz = 4;
        default:    legal = 1'b0;
      endcase
    end
    in  = (a >= BASE) && (a < BASE + 32'd4096);
    off = a - BASE;
    e   = !legal || !in || ((off % 32'(sz)) != 0);
    r   = 32'd0;
    if (e) return;
    wi   = int'(off / 4);
    b    = int'(off % 4);
    word = mm[k][wi];
    if (w) begin
      for (int i = 0; i < sz; i++)
        word[8*(b+i) +: 8] = d[8*i +: 8];
      mm[k][wi] = word;
    end else begin
      mask = (sz == 4) ? 32'hFFFFFFFF : ((32'd1 << (8*sz)) - 32'd1);
      v = (word >> (8*b)) & mask;
      if (f < 3'd4 && sz < 4 && v[8*sz-1]) v = v | ~mask;
      r = v;
    end
  endfunction

  task automatic xact(input int k, input logic [31:0] a, input logic w,
                      input logic [2:0] f, input logic [31:0] d,
                      input string tag,
                      output logic [31:0] r, output logic e);
    logic [31:0] er;
    logic ee;
    int n, lat;
    model(k, a, w, f, d, er, ee);
    @(negedge clk);
    qv[k] = 1'b1; qa[k] = a; qw[k] = w; qf[k] = f; qd[k] = d;
    pr[k] = 1'b1;
    n = 0;
    while (!qr[k] && n < 20) begin @(negedge clk); n++; end
    if (!qr[k]) chk($sformatf("%s_acc_tmo", tag), 32'd0, 32'd1);
    @(posedge clk);
    #1;
    qv[k] = 1'b0; qa[k] = $urandom; qd[k] = $urandom;
    qw[k] = 1'($urandom); qf[k] = 3'($urandom);
    lat = 1;
    @(negedge clk);
    while (!pv[k] && lat < 20) begin @(negedge clk); lat++; end
    r = pd[k];
    e = pe[k];
    chk($sformatf("%s_lat", tag), 32'(lat), (k == 0) ? 32'd2 : 32'd1);
    chk($sformatf("%s_data", tag), pd[k], er);
    chk($sformatf("%s_err", tag), 32'(pe[k]), 32'(ee));
    @(negedge clk);
    chk($sformatf("%s_done", tag), 32'(pv[k]), 32'd0);
  endtask

  initial begin
    logic [31:0] r, er, hold, prior;
    logic e, ee;
    int n, acc, last, sel;
    logic [31:0] a;

    for (int k = 0; k < 2; k++) begin
      qv[k] = 1'b0; qa[k] = '0; qd[k] = '0;
      qw[k] = 1'b0; qf[k] = '0; pr[k] = 1'b1;
    end

    repeat (3) @(negedge clk);
    chk("rst_rdy",  32'(qr[0]), 32'd0);
    chk("rst_vld",  32'(pv[0]), 32'd0);
    chk("rst_data", pd[0], 32'd0);
    chk("rst_err",  32'(pe[0]), 32'd0);
    chk("rst_busy", 32'(bz[0]), 32'd0);
    rst = 1'b0;
    #1 chk("rdy_pre", 32'(qr[0]), 32'd0);
    @(posedge clk);
    #1 chk("rdy_post", 32'(qr[0]), 32'd1);

    for (int i = 0; i < 16; i++)
      xact(0, BASE + 32'(4*i), 1'b1, 3'd2, $urandom, "init", r, e);
    xact(0, BASE + 32'd4092, 1'b1, 3'd2, 32'hC0FFEE11, "init_top", r, e);

    xact(0, BASE, 1'b1, 3'd2, 32'hDEADBEEF, "sw", r, e);
    xact(0, BASE, 1'b0, 3'd2, 32'd0, "lw", r, e);
    chk("lw_const", r, 32'hDEADBEEF);
    chk("lw_err", 32'(e), 32'd0);

    xact(0, BASE, 1'b1, 3'd2, 32'd0, "sw0", r, e);
    xact(0, BASE + 32'd3, 1'b1, 3'd0, 32'h00000080, "sb", r, e);
    xact(0, BASE + 32'd3, 1'b0, 3'd0, 32'd0, "lb", r, e);
    chk("lb_const", r, 32'hFFFFFF80);
    xact(0, BASE + 32'd3, 1'b0, 3'd4, 32'd0, "lbu", r, e);
    chk("lbu_const", r, 32'h00000080);
    xact(0, BASE, 1'b0, 3'd2, 32'd0, "lw2", r, e);
    chk("lw2_const", r, 32'h80000000);

    xact(0, BASE + 32'd1, 1'b0, 3'd1, 32'd0, "lh_mis", r, e);
    chk("lh_mis_err", 32'(e), 32'd1);
    chk("lh_mis_data", r, 32'd0);
    xact(0, 32'h01FFFFFC, 1'b1, 3'd2, 32'h55AA55AA, "sw_low", r, e);
    chk("sw_low_err", 32'(e), 32'd1);

    model(0, BASE + 32'd8, 1'b0, 3'd2, 32'd0, er, ee);
    @(negedge clk);
    pr[0] = 1'b0; qv[0] = 1'b1; qa[0] = BASE + 32'd8;
    qw[0] = 1'b0; qf[0] = 3'd2;
    n = 0;
    while (!qr[0] && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 qv[0] = 1'b0;
    @(negedge clk);
    n = 1;
    while (!pv[0] && n < 20) begin @(negedge clk); n++; end
    chk("bp_data", pd[0], er);
    hold = pd[0];
    repeat (5) begin
      @(negedge clk);
      chk("bp_vld",  32'(pv[0]), 32'd1);
      chk("bp_hold", pd[0], hold);
      chk("bp_rdy",  32'(qr[0]), 32'd0);
      chk("bp_busy", 32'(bz[0]), 32'd1);
    end
    pr[0] = 1'b1;
    @(negedge clk);
    chk("bp_end_vld",  32'(pv[0]), 32'd0);
    chk("bp_end_busy", 32'(bz[0]), 32'd0);
    chk("bp_end_rdy",  32'(qr[0]), 32'd1);

    prior = mm[0][4];
    @(negedge clk);
    qv[0] = 1'b1; qa[0] = BASE + 32'd16; qw[0] = 1'b1;
    qf[0] = 3'd2; qd[0] = 32'h12345678;
    n = 0;
    while (!qr[0] && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 qv[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(bz[0]), 32'd0);
    chk("mid_rst_vld",  32'(pv[0]), 32'd0);
    chk("mid_rst_rdy",  32'(qr[0]), 32'd0);
    @(negedge clk);
    chk("mid_rst_busy2", 32'(bz[0]), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    xact(0, BASE + 32'd16, 1'b0, 3'd2, 32'd0, "post_rst", r, e);
    chk("post_rst_prior", r, prior);

    for (int i = 0; i < 80; i++) begin
      sel = int'($urandom_range(0, 7));
      if (sel == 0)
        a = BASE - 32'($urandom_range(1, 8));
      else if (sel == 1)
        a = BASE + 32'd4096 + 32'($urandom_range(0, 7));
      else
        a = BASE + 32'($urandom_range(0, 63));
      xact(0, a, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           $urandom, "rnd", r, e);
    end

    for (int i = 0; i < 16; i++)
      xact(0, BASE + 32'(4*i), 1'b0, 3'd2, 32'd0, "sweep", r, e);
    xact(0, BASE + 32'd4092, 1'b0, 3'd2, 32'd0, "sweep_top", r, e);
    chk("sweep_top_const", r, 32'hC0FFEE11);

    xact(1, BASE, 1'b1, 3'd2, 32'hA5A51234, "l1_sw", r, e);
    xact(1, BASE, 1'b0, 3'd2, 32'd0, "l1_lw", r, e);
    chk("l1_lw_const", r, 32'hA5A51234);

    @(negedge clk);
    qv[1] = 1'b1; qa[1] = BASE; qw[1] = 1'b0; qf[1] = 3'd2; pr[1] = 1'b1;
    acc = 0;
    last = -1;
    for (int c = 0; c < 20; c++) begin
      if (qr[1]) begin
        acc++;
        if (last >= 0) chk("b2b_gap", 32'(c - last), 32'd2);
        last = c;
      end
      if (pv[1]) chk("b2b_data", pd[1], 32'hA5A51234);
      @(negedge clk);
    end
    qv[1] = 1'b0;
    chk("b2b_count", 32'(acc), 32'd10);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
